skew_feed_ctrl: RTL

SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

---
 rtl/skew_feed_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/skew_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skew_feed_ctrl
// Brief    : Row-to-systolic skew feeder. Lane k presents an accepted row
//            element k+1 cycles after acceptance; IDLE/RUN/DRAIN frame FSM.
//            Optional macro SKEW_FEED_STALL_EN adds i_stall (global hold).
// Revision : 1.0 - initial release
// ============================================================================
module skew_feed_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic                        i_last,
    input  logic [LANES*DATA_WIDTH-1:0] i_data,
`ifdef SKEW_FEED_STALL_EN
    input  logic                        i_stall,
`endif
    output logic                        o_ready,
    output logic [LANES*DATA_WIDTH-1:0] o_data,
    output logic [LANES-1:0]            o_lane_valid,
    output logic                        o_last,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int c_CNT_W = $clog2(LANES);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(LANES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_done;
    logic               w_done_next;
    logic               w_stall;
    logic               w_advance;
    logic               w_ready;
    logic               w_accept;

`ifdef SKEW_FEED_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_advance = ~w_stall;
    assign w_accept  = i_valid & w_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (w_advance) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            c_IDLE, c_RUN: begin
                if (w_accept) begin
                    if (i_last) begin
                        w_state_next = c_DRAIN;
                        w_cnt_next   = c_DRAIN_LOAD;
                    end else begin
                        w_state_next = c_RUN;
                    end
                end
            end
            c_DRAIN: begin
                // Leave as the counter steps to zero so the done cycle is IDLE
                w_cnt_next = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = c_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            c_IDLE:  w_ready = w_advance;
            c_RUN: begin
                w_ready = w_advance;
                o_busy  = 1'b1;
            end
            c_DRAIN: o_busy = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    assign o_ready = w_ready;
    assign o_done  = r_done & w_advance;

    // ------------------------------------------------------------------
    // Per-lane delay lines; lane k is k+1 stages deep
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_sh [0:k];
        logic                  r_vl [0:k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= k; s++) begin
                    r_sh[s] <= '0;
                    r_vl[s] <= 1'b0;
                end
            end else if (w_advance) begin
                // Non-accepted cycles enter as zero-data bubbles
                r_sh[0] <= w_accept ? i_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_vl[0] <= w_accept;
                for (int s = k; s > 0; s--) begin
                    r_sh[s] <= r_sh[s-1];
                    r_vl[s] <= r_vl[s-1];
                end
            end
        end

        assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = w_advance ? r_sh[k] : '0;
        assign o_lane_valid[k]                    = r_vl[k] & w_advance;
    end : g_lane

    // Last-row marker travels alongside the deepest lane
    logic r_last_sh [0:LANES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LANES; s++) begin
                r_last_sh[s] <= 1'b0;
            end
        end else if (w_advance) begin
            r_last_sh[0] <= w_accept & i_last;
            for (int s = LANES - 1; s > 0; s--) begin
                r_last_sh[s] <= r_last_sh[s-1];
            end
        end
    end

    assign o_last = r_last_sh[LANES-1] & w_advance;

endmodule : skew_feed_ctrl
`default_nettype wire
